// File: rtl/keypad_pkg.sv
// Shared types and the key layout for the 4x4 Pmod keypad scanner.
// KEYMAP is indexed [column][row], matching the col_n / row_n bit order.
package keypad_pkg;

    typedef enum logic [1:0] {
        NONE,
        ONE,
        MULTI
    } frame_res_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CONFIRM,
        HELD,
        RELEASE_CONFIRM
    } key_state_t;

    localparam logic [3:0] KEYMAP [0:3][0:3] = '{
        '{4'h1, 4'h4, 4'h7, 4'h0},
        '{4'h2, 4'h5, 4'h8, 4'hF},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

endpackage

// File: rtl/keypad_frame_scan.sv
// Column scanning, row synchronisation and per-frame key classification.
// frame_done is high on the last cycle of the col3 dwell, with the frame verdict alongside it.
module keypad_frame_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       frame_done,
    output frame_res_t frame_result,
    output logic [3:0] frame_code
);

    localparam int DW = $clog2(SCAN_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

    logic [DW-1:0] r_dwell;
    logic [1:0]    r_col;
    logic [3:0]    r_row_meta;
    logic [3:0]    r_row_sync;
    logic          r_seen;
    logic          r_multi;
    logic [3:0]    r_code;

    logic       w_sample;
    logic [3:0] w_rows;
    logic       w_col_any;
    logic       w_col_one;
    logic [1:0] w_row_idx;
    logic       w_seen_now;
    logic       w_multi_now;
    logic [3:0] w_code_now;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row_n;
            r_row_sync <= r_row_meta;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell <= '0;
            r_col   <= 2'd0;
        end else if (r_dwell == DWELL_LAST) begin
            r_dwell <= '0;
            r_col   <= r_col + 2'd1;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    assign col_n    = ~(4'b0001 << r_col);
    assign w_sample = (r_dwell == DWELL_LAST);
    assign w_rows   = ~r_row_sync;

    // Sampling at the end of the dwell leaves the synchroniser time to settle after a column change.
    assign w_col_any = |w_rows;
    assign w_col_one = w_col_any && ((w_rows & (w_rows - 4'd1)) == 4'd0);

    always_comb begin
        w_row_idx = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (w_rows[r]) begin
                w_row_idx = 2'(r);
            end
        end
    end

    assign w_seen_now  = r_seen | w_col_any;
    assign w_multi_now = r_multi | (w_col_any & (~w_col_one | r_seen));
    assign w_code_now  = (w_col_one && !r_seen) ? KEYMAP[r_col][w_row_idx] : r_code;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_seen  <= 1'b0;
            r_multi <= 1'b0;
            r_code  <= 4'h0;
        end else if (w_sample) begin
            if (r_col == 2'd3) begin
                r_seen  <= 1'b0;
                r_multi <= 1'b0;
                r_code  <= 4'h0;
            end else begin
                r_seen  <= w_seen_now;
                r_multi <= w_multi_now;
                r_code  <= w_code_now;
            end
        end
    end

    assign frame_done   = w_sample && (r_col == 2'd3);
    assign frame_code   = w_code_now;
    assign frame_result = !w_seen_now ? NONE : (w_multi_now ? MULTI : ONE);

endmodule

// File: rtl/keypad_scanner.sv
// Debounced 4x4 keypad front end: one key_valid pulse per accepted press.
// The debounce FSM advances only on frame_done; key outputs are registered at that same edge.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [3:0] col_n,
    input  logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output key_state_t dbg_state
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic       w_frame_done;
    frame_res_t w_frame_result;
    logic [3:0] w_frame_code;

    key_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_cand;
    logic [3:0]    r_key_code;
    logic          r_key_valid;
    logic          r_key_held;

    key_state_t    w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_cnt_inc;
    logic [3:0]    w_cand_next;
    logic          w_accept;
    logic          w_release;

    keypad_frame_scan #(
        .SCAN_CYCLES(SCAN_CYCLES)
    ) u_frame_scan (
        .clock        (clock),
        .reset_n      (reset_n),
        .row_n        (row_n),
        .col_n        (col_n),
        .frame_done   (w_frame_done),
        .frame_result (w_frame_result),
        .frame_code   (w_frame_code)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cand  <= 4'h0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cand  <= w_cand_next;
        end
    end

    assign w_cnt_inc = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        if (w_frame_done) begin
            case (r_state)
                IDLE: begin
                    if (w_frame_result == ONE) begin
                        w_cand_next  = w_frame_code;
                        w_cnt_next   = (DEBOUNCE_SCANS == 1) ? '0 : CNT_ONE;
                        w_state_next = (DEBOUNCE_SCANS == 1) ? HELD : PRESS_CONFIRM;
                    end
                end
                PRESS_CONFIRM: begin
                    if (w_frame_result != ONE) begin
                        w_cnt_next   = '0;
                        w_state_next = IDLE;
                    end else if (w_frame_code != r_cand) begin
                        w_cand_next = w_frame_code;
                        w_cnt_next  = CNT_ONE;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        w_cnt_next   = '0;
                        w_state_next = HELD;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                HELD: begin
                    // Other keys arriving while held are ignored: no rollover, no repeat.
                    if (w_frame_result == NONE) begin
                        w_cnt_next   = (DEBOUNCE_SCANS == 1) ? '0 : CNT_ONE;
                        w_state_next = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE_CONFIRM;
                    end
                end
                RELEASE_CONFIRM: begin
                    if (w_frame_result != NONE) begin
                        w_cnt_next   = '0;
                        w_state_next = HELD;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        w_cnt_next   = '0;
                        w_state_next = IDLE;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
                default: begin
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_accept  = 1'b0;
        w_release = 1'b0;
        if ((r_state == IDLE || r_state == PRESS_CONFIRM) && w_state_next == HELD) begin
            w_accept = 1'b1;
        end
        if ((r_state == HELD || r_state == RELEASE_CONFIRM) && w_state_next == IDLE) begin
            w_release = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= w_cand_next;
                r_key_held <= 1'b1;
            end else if (w_release) begin
                r_key_held <= 1'b0;
            end
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign dbg_state = r_state;

endmodule
